// File: rtl/rng_pkg.sv
// rng_pkg: shared state type, default LCG constants and the LCG step function for rng_roller
package rng_pkg;
  typedef enum logic {S_IDLE, S_ROLL} roll_state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LCG_A = 9;
  localparam int DEF_LCG_C = 15;
  localparam int DEF_SEED = 0;
  function automatic logic [63:0] lcg_next(input logic [63:0] x, input logic [63:0] a, input logic [63:0] c);
    return x * a + c;
  endfunction
endpackage

// File: rtl/rng_roller_if.sv
// rng_roller_if: roll control/status bundle; master drives start/stop/seed, slave returns value/busy/done
interface rng_roller_if #(parameter int WIDTH = 4) ();
  logic i_start;
  logic i_stop;
  logic i_seed_load;
  logic [WIDTH-1:0] i_seed;
  logic [WIDTH-1:0] o_random_out;
  logic o_busy;
  logic o_done;
  modport master (output i_start, i_stop, i_seed_load, i_seed, input o_random_out, o_busy, o_done);
  modport slave (input i_start, i_stop, i_seed_load, i_seed, output o_random_out, o_busy, o_done);
endinterface

// File: rtl/lcg_core.sv
// lcg_core: free-running LCG register; ports i_clk, i_rst_n (async low), i_seed_load/i_seed (load), o_state
module lcg_core import rng_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LCG_A = DEF_LCG_A,
  parameter int LCG_C = DEF_LCG_C,
  parameter int SEED = DEF_SEED
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_state
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_state <= WIDTH'(SEED);
    else o_state <= i_seed_load ? i_seed : WIDTH'(lcg_next(64'(o_state), 64'(LCG_A), 64'(LCG_C)));
endmodule

// File: rtl/rng_roller.sv
// rng_roller: dice roller sampling an LCG N_STEPS times with growing gaps
// ports: i_clk, i_rst_n (async low), bus (slave: start/stop/seed in; random_out/busy/done out)
module rng_roller import rng_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LCG_A = DEF_LCG_A,
  parameter int LCG_C = DEF_LCG_C,
  parameter int SEED = DEF_SEED,
  parameter int N_STEPS = 16,
  parameter int PRESCALE = 1
) (
  input logic i_clk,
  input logic i_rst_n,
  rng_roller_if.slave bus
);
  localparam int GW = $clog2(N_STEPS * PRESCALE + 1);
  localparam int SW = $clog2(N_STEPS + 1);
  roll_state_e state_r, state_n;
  logic [SW-1:0] step_r, step_n;
  logic [GW-1:0] gap_r, gap_n;
  logic [WIDTH-1:0] x, out_r, out_n;
  logic done_r, done_n, hit, last;
  lcg_core #(.WIDTH(WIDTH), .LCG_A(LCG_A), .LCG_C(LCG_C), .SEED(SEED)) u_lcg (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_seed_load(bus.i_seed_load),
    .i_seed(bus.i_seed),
    .o_state(x)
  );
  // after sample k the next one is due k*PRESCALE cycles later; step_r == N_STEPS-1 means the next sample is the final one
  assign hit = int'(gap_r) == int'(step_r) * PRESCALE - 1;
  assign last = int'(step_r) == N_STEPS - 1;
  always_comb begin
    state_n = state_r;
    step_n = step_r;
    gap_n = gap_r;
    out_n = out_r;
    done_n = 1'b0;
    if (state_r == S_IDLE) begin
      if (bus.i_start) begin
        out_n = x;
        step_n = SW'(1);
        gap_n = '0;
        done_n = N_STEPS == 1;
        state_n = N_STEPS == 1 ? S_IDLE : S_ROLL;
      end
    end else if (bus.i_stop) begin
      out_n = x;
      done_n = 1'b1;
      state_n = S_IDLE;
    end else if (bus.i_start) begin
      out_n = x;
      step_n = SW'(1);
      gap_n = '0;
    end else if (hit) begin
      out_n = x;
      step_n = step_r + SW'(1);
      gap_n = '0;
      done_n = last;
      state_n = last ? S_IDLE : S_ROLL;
    end else begin
      gap_n = gap_r + GW'(1);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      step_r <= '0;
      gap_r <= '0;
      out_r <= '0;
      done_r <= 1'b0;
    end else begin
      state_r <= state_n;
      step_r <= step_n;
      gap_r <= gap_n;
      out_r <= out_n;
      done_r <= done_n;
    end
  assign bus.o_random_out = out_r;
  assign bus.o_busy = state_r == S_ROLL;
  assign bus.o_done = done_r;
endmodule

// File: tb/tb_rng_roller.sv
// tb_rng_roller: directed self-checking bench for rng_roller (WIDTH=4, A=9, C=15, SEED=0, N_STEPS=4)
module tb_rng_roller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rng_roller_if #(.WIDTH(4)) if_a ();
  rng_roller_if #(.WIDTH(4)) if_b ();
  rng_roller #(.WIDTH(4), .LCG_A(9), .LCG_C(15), .SEED(0), .N_STEPS(4), .PRESCALE(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
  rng_roller #(.WIDTH(4), .LCG_A(9), .LCG_C(15), .SEED(0), .N_STEPS(4), .PRESCALE(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    if_a.i_start = 0; if_a.i_stop = 0; if_a.i_seed_load = 0; if_a.i_seed = 0;
    if_b.i_start = 0; if_b.i_stop = 0; if_b.i_seed_load = 0; if_b.i_seed = 0;
    rst_n = 0;
    #12;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic setup_roll();
    if_a.i_seed_load = 1; if_a.i_seed = 0;
    tick();
    if_a.i_seed_load = 0;
    tick();
    if_a.i_start = 1;
    tick();
    if_a.i_start = 0;
  endtask
  task automatic test_reset();
    logic [3:0] lcg_exp [4] = '{4'd0, 4'd15, 4'd6, 4'd5};
    do_reset();
    checks++;
    if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 00", {if_a.o_random_out, if_a.o_busy, if_a.o_done});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.u_lcg.o_state !== lcg_exp[i]) begin
        errors++;
        $display("FAIL lcg_orbit[%0d] got %0d want %0d", i, dut_a.u_lcg.o_state, lcg_exp[i]);
      end
      tick();
    end
  endtask
  task automatic test_full_roll();
    logic [5:0] exp [8] = '{{4'd15, 2'b10}, {4'd6, 2'b10}, {4'd6, 2'b10}, {4'd12, 2'b10},
                            {4'd12, 2'b10}, {4'd12, 2'b10}, {4'd1, 2'b01}, {4'd1, 2'b00}};
    do_reset();
    setup_roll();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== exp[i]) begin
        errors++;
        $display("FAIL full_roll E+%0d got %h want %h", i + 2, {if_a.o_random_out, if_a.o_busy, if_a.o_done}, exp[i]);
      end
      tick();
    end
  endtask
  task automatic test_stop();
    do_reset();
    setup_roll();
    tick();
    if_a.i_stop = 1;
    tick();
    if_a.i_stop = 0;
    checks++;
    if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== {4'd5, 2'b01}) begin
      errors++;
      $display("FAIL stop_edge got %h want %h", {if_a.o_random_out, if_a.o_busy, if_a.o_done}, {4'd5, 2'b01});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== {4'd5, 2'b00}) begin
        errors++;
        $display("FAIL stop_hold[%0d] got %h want %h", i, {if_a.o_random_out, if_a.o_busy, if_a.o_done}, {4'd5, 2'b00});
      end
    end
  endtask
  task automatic test_restart();
    logic [5:0] exp [8] = '{{4'd5, 2'b10}, {4'd12, 2'b10}, {4'd12, 2'b10}, {4'd2, 2'b10},
                            {4'd2, 2'b10}, {4'd2, 2'b10}, {4'd7, 2'b01}, {4'd7, 2'b00}};
    do_reset();
    setup_roll();
    tick();
    if_a.i_start = 1;
    tick();
    if_a.i_start = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== exp[i]) begin
        errors++;
        $display("FAIL restart E+%0d got %h want %h", i + 4, {if_a.o_random_out, if_a.o_busy, if_a.o_done}, exp[i]);
      end
      tick();
    end
  endtask
  task automatic test_start_stop();
    do_reset();
    setup_roll();
    tick();
    if_a.i_start = 1; if_a.i_stop = 1;
    tick();
    checks++;
    if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== {4'd5, 2'b01}) begin
      errors++;
      $display("FAIL both_in_roll got %h want %h", {if_a.o_random_out, if_a.o_busy, if_a.o_done}, {4'd5, 2'b01});
    end
    tick();
    if_a.i_start = 0; if_a.i_stop = 0;
    checks++;
    if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== {4'd12, 2'b10}) begin
      errors++;
      $display("FAIL both_in_idle got %h want %h", {if_a.o_random_out, if_a.o_busy, if_a.o_done}, {4'd12, 2'b10});
    end
  endtask
  task automatic test_reset_mid_roll();
    do_reset();
    setup_roll();
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got %h want 00", {if_a.o_random_out, if_a.o_busy, if_a.o_done});
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({if_a.o_random_out, if_a.o_busy, if_a.o_done} !== 6'b0) begin
        errors++;
        $display("FAIL after_reset[%0d] got %h want 00", i, {if_a.o_random_out, if_a.o_busy, if_a.o_done});
      end
    end
  endtask
  task automatic test_prescale();
    logic [3:0] exp_out, prev;
    int last_change;
    int gaps [$];
    do_reset();
    if_b.i_seed_load = 1; if_b.i_seed = 0;
    tick();
    if_b.i_seed_load = 0;
    tick();
    if_b.i_start = 1;
    tick();
    if_b.i_start = 0;
    prev = if_b.o_random_out;
    last_change = 2;
    for (int c = 2; c < 22; c++) begin
      exp_out = c < 5 ? 4'd15 : c < 11 ? 4'd12 : c < 20 ? 4'd14 : 4'd5;
      checks++;
      if ({if_b.o_random_out, if_b.o_busy, if_b.o_done} !== {exp_out, c < 20, c == 20}) begin
        errors++;
        $display("FAIL prescale E+%0d got %h want %h", c, {if_b.o_random_out, if_b.o_busy, if_b.o_done}, {exp_out, c < 20, c == 20});
      end
      if (if_b.o_random_out !== prev) begin
        gaps.push_back(c - last_change);
        last_change = c;
        prev = if_b.o_random_out;
      end
      tick();
    end
    checks++;
    if (gaps.size() != 3) begin
      errors++;
      $display("FAIL prescale_gap_count got %0d want 3", gaps.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gaps[i] != 3 * (i + 1)) begin
          errors++;
          $display("FAIL prescale_gap[%0d] got %0d want %0d", i, gaps[i], 3 * (i + 1));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_roll();
    test_stop();
    test_restart();
    test_start_stop();
    test_reset_mid_roll();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
